// File: rtl/apb_request_arbiter.sv
// rtl/apb_request_arbiter.sv - round-robin arbiter sharing one APB master command port among N_REQ requesters
module apb_request_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int SEL_W   = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*SEL_W-1:0]  req_sel,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        ack,
   output logic                    err,
   output logic [DATA_W-1:0]       rdata,
   output logic [N_REQ-1:0]        grant,
   output logic                    m_start,
   output logic [SEL_W-1:0]        m_sel,
   output logic                    m_write,
   output logic [ADDR_W-1:0]       m_addr,
   output logic [DATA_W-1:0]       m_wdata,
   input  logic                    m_stable,
   input  logic [DATA_W-1:0]       m_rdata
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] win;
   logic [IDX_W-1:0] cand;
   logic             found;
   logic             seen_low;
   logic [7:0]       wd;

   // First pending requester at or after rr_ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         idx      <= '0;
         seen_low <= 1'b0;
         wd       <= '0;
         ack      <= '0;
         err      <= 1'b0;
         rdata    <= '0;
         grant    <= '0;
         m_start  <= 1'b0;
         m_sel    <= '0;
         m_write  <= 1'b0;
         m_addr   <= '0;
         m_wdata  <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               seen_low <= 1'b0;
               if (found) begin
                  idx     <= win;
                  grant   <= N_REQ'(1) << win;
                  m_sel   <= req_sel[win*SEL_W +: SEL_W];
                  m_write <= req_write[win];
                  m_addr  <= req_addr[win*ADDR_W +: ADDR_W];
                  m_wdata <= req_wdata[win*DATA_W +: DATA_W];
                  // Slave select 0 addresses nothing: fail straight away, never touch the bus.
                  if (req_sel[win*SEL_W +: SEL_W] == '0) begin
                     ack   <= N_REQ'(1) << win;
                     err   <= 1'b1;
                     state <= DONE;
                  end else begin
                     m_start <= 1'b1;
                     state   <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               m_start  <= 1'b0;
               wd       <= '0;
               seen_low <= 1'b0;
               state    <= WAIT;
            end
            WAIT: begin
               wd <= wd + 8'd1;
               if (!m_stable) seen_low <= 1'b1;
               if (seen_low && m_stable) begin
                  if (!m_write) rdata <= m_rdata;
                  err   <= 1'b0;
                  ack   <= grant;
                  state <= DONE;
               end else if (wd == 8'(TIMEOUT - 1)) begin
                  err   <= 1'b1;
                  ack   <= grant;
                  state <= DONE;
               end
            end
            DONE: begin
               err    <= 1'b0;
               grant  <= '0;
               rr_ptr <= IDX_W'((int'(idx) + 1) % N_REQ);
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_request_arbiter.sv
// tb/tb_apb_request_arbiter.sv - randomized self-checking bench for apb_request_arbiter
`timescale 1ns/1ps
module tb_apb_request_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 2;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*SW-1:0] req_sel;
   logic [N-1:0]    req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    ack;
   logic            err;
   logic [DW-1:0]   rdata;
   logic [N-1:0]    grant;
   logic            m_start;
   logic [SW-1:0]   m_sel;
   logic            m_write;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic            m_stable;
   logic [DW-1:0]   m_rdata;

   always #5 clk = ~clk;

   apb_request_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .req(req), .req_sel(req_sel), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata),
      .grant(grant), .m_start(m_start), .m_sel(m_sel), .m_write(m_write), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_stable(m_stable), .m_rdata(m_rdata));

   int n_cmp = 0;
   int n_bad = 0;

   logic [SW-1:0] c_sel   [N];
   logic          c_write [N];
   logic [AW-1:0] c_addr  [N];
   logic [DW-1:0] c_wdata [N];
   int            mdl_rr;
   logic [DW-1:0] mdl_rdata;

   typedef struct packed {
      logic [N-1:0]  gnt;
      logic [N-1:0]  ackv;
      logic [N-1:0]  ack_next;
      logic          errv;
      logic [DW-1:0] rdv;
      int            starts;
      int            lat;
      logic [SW-1:0] s_sel;
      logic          s_write;
      logic [AW-1:0] s_addr;
      logic [DW-1:0] s_wdata;
   } obs_t;

   function automatic int pick(input logic [N-1:0] r, input int ptr);
      for (int k = 0; k < N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic set_cmd(input int i, input logic [SW-1:0] s, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      c_sel[i] = s; c_write[i] = w; c_addr[i] = a; c_wdata[i] = d;
      req_sel[i*SW +: SW]   = s;
      req_write[i]          = w;
      req_addr[i*AW +: AW]  = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   // Plays the APB master (stable low for lat cycles after start) and records what the arbiter did.
   task automatic serve(input int lat, input logic [DW-1:0] rd, input bit hang, output obs_t o);
      int phase;
      int start_cyc;
      phase = -1;
      start_cyc = 0;
      o = '0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         @(negedge clk);
         if (grant != '0) o.gnt = grant;
         if (m_start) begin
            o.starts++;
            phase = 0;
            start_cyc = cyc;
            o.s_sel = m_sel; o.s_write = m_write; o.s_addr = m_addr; o.s_wdata = m_wdata;
         end
         if (ack != '0) begin
            o.ackv = ack; o.errv = err; o.rdv = rdata; o.lat = cyc - start_cyc;
            req = req & ~ack;
            break;
         end
         if (phase >= 0 && !hang) begin
            m_stable = (phase >= lat);
            if (phase >= lat) m_rdata = rd;
            phase++;
         end
      end
      @(negedge clk);
      o.ack_next = ack;
      m_stable = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if ({ack, err, rdata, grant} !== '0) begin n_bad++;
         $display("FAIL reset_status: got %h expected 0", {ack, err, rdata, grant}); end
      n_cmp++; if ({m_start, m_sel, m_write, m_addr, m_wdata} !== '0) begin n_bad++;
         $display("FAIL reset_master: got %h expected 0", {m_start, m_sel, m_write, m_addr, m_wdata}); end
      reset = 1'b0;
      mdl_rr = 0; mdl_rdata = '0;
      @(negedge clk);
      n_cmp++; if ({grant, m_start, ack} !== '0) begin n_bad++;
         $display("FAIL idle_after_reset: got %h expected 0", {grant, m_start, ack}); end
   endtask

   task automatic test_single_read();
      obs_t o;
      set_cmd(0, 2'd1, 1'b0, 32'h10, 32'h0);
      req = 4'b0001;
      serve(2, 32'hA5A5_0001, 1'b0, o);
      n_cmp++; if (o.starts !== 1) begin n_bad++; $display("FAIL single_starts: got %0d expected 1", o.starts); end
      n_cmp++; if (o.gnt !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b expected 0001", o.gnt); end
      n_cmp++; if ({o.s_sel, o.s_write, o.s_addr} !== {2'd1, 1'b0, 32'h10}) begin n_bad++;
         $display("FAIL single_cmd: got %h expected %h", {o.s_sel, o.s_write, o.s_addr}, {2'd1, 1'b0, 32'h10}); end
      n_cmp++; if ({o.ackv, o.errv} !== {4'b0001, 1'b0}) begin n_bad++;
         $display("FAIL single_ack: got %b/%b expected 0001/0", o.ackv, o.errv); end
      n_cmp++; if (o.rdv !== 32'hA5A5_0001) begin n_bad++; $display("FAIL single_rdata: got %h expected a5a50001", o.rdv); end
      n_cmp++; if (o.lat !== 3) begin n_bad++; $display("FAIL single_latency: got %0d expected 3", o.lat); end
      n_cmp++; if (o.ack_next !== '0) begin n_bad++; $display("FAIL single_ack_width: got %b expected 0000", o.ack_next); end
      mdl_rdata = 32'hA5A5_0001;
      mdl_rr = 1;
   endtask

   task automatic test_round_robin();
      obs_t o;
      logic [N-1:0] order [5];
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < N; i++) set_cmd(i, SW'(i % 3 + 1), 1'b0, AW'(32'h100 + i), DW'(i));
      mdl_rr = 0;
      reset = 1'b1; @(negedge clk); reset = 1'b0; mdl_rdata = '0;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         serve(2, 32'hC000_0000 + t, 1'b0, o);
         n_cmp++; if (o.gnt !== order[t]) begin n_bad++;
            $display("FAIL rr_grant[%0d]: got %b expected %b", t, o.gnt, order[t]); end
         n_cmp++; if ({o.ackv, o.errv, o.ack_next} !== {order[t], 1'b0, 4'b0000}) begin n_bad++;
            $display("FAIL rr_ack[%0d]: got %b/%b/%b expected %b/0/0000", t, o.ackv, o.errv, o.ack_next, order[t]); end
         n_cmp++; if (o.rdv !== 32'hC000_0000 + t) begin n_bad++;
            $display("FAIL rr_rdata[%0d]: got %h expected %h", t, o.rdv, 32'hC000_0000 + t); end
         mdl_rdata = 32'hC000_0000 + t;
         req = 4'b1111;
      end
      req = '0;
      mdl_rr = 1;
   endtask

   task automatic test_wrap();
      obs_t o;
      req = 4'b0100;
      serve(2, 32'h1111_2222, 1'b0, o);
      mdl_rdata = 32'h1111_2222;
      req = 4'b1001;
      serve(3, 32'h3333_4444, 1'b0, o);
      n_cmp++; if (o.gnt !== 4'b1000) begin n_bad++; $display("FAIL wrap_first: got %b expected 1000", o.gnt); end
      serve(2, 32'h5555_6666, 1'b0, o);
      n_cmp++; if (o.gnt !== 4'b0001) begin n_bad++; $display("FAIL wrap_second: got %b expected 0001", o.gnt); end
      mdl_rdata = 32'h5555_6666;
      mdl_rr = 1;
   endtask

   task automatic test_timeout();
      obs_t o;
      set_cmd(1, 2'd2, 1'b0, 32'h40, 32'h0);
      req = 4'b0010;
      serve(2, 32'hDEAD_BEEF, 1'b1, o);
      n_cmp++; if ({o.ackv, o.errv} !== {4'b0010, 1'b1}) begin n_bad++;
         $display("FAIL timeout_ack: got %b/%b expected 0010/1", o.ackv, o.errv); end
      n_cmp++; if (o.lat !== TO + 1) begin n_bad++; $display("FAIL timeout_latency: got %0d expected %0d", o.lat, TO + 1); end
      n_cmp++; if (o.rdv !== mdl_rdata) begin n_bad++; $display("FAIL timeout_rdata: got %h expected %h", o.rdv, mdl_rdata); end
      mdl_rr = 2;
   endtask

   task automatic test_invalid_sel();
      obs_t o;
      set_cmd(1, 2'd0, 1'b1, 32'h80, 32'h77);
      req = 4'b0010;
      serve(2, 32'h0, 1'b0, o);
      n_cmp++; if (o.starts !== 0) begin n_bad++; $display("FAIL badsel_start: got %0d expected 0", o.starts); end
      n_cmp++; if ({o.ackv, o.errv} !== {4'b0010, 1'b1}) begin n_bad++;
         $display("FAIL badsel_ack: got %b/%b expected 0010/1", o.ackv, o.errv); end
      n_cmp++; if (o.lat > 2) begin n_bad++; $display("FAIL badsel_latency: got %0d expected <=2", o.lat); end
      n_cmp++; if (o.ack_next !== '0) begin n_bad++; $display("FAIL badsel_ack_width: got %b expected 0000", o.ack_next); end
      mdl_rr = 2;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      bit seen;
      seen = 1'b0;
      set_cmd(1, 2'd1, 1'b0, 32'h20, 32'h0);
      set_cmd(2, 2'd3, 1'b0, 32'h30, 32'h0);
      req = 4'b0100;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = m_start;
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL rstmid_start: got 0 expected 1"); end
      m_stable = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_cmp++; if ({ack, err, rdata, grant, m_start, m_sel, m_write, m_addr, m_wdata} !== '0) begin n_bad++;
         $display("FAIL rstmid_outputs: got %h expected 0",
                  {ack, err, rdata, grant, m_start, m_sel, m_write, m_addr, m_wdata}); end
      m_stable = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mdl_rr = 0; mdl_rdata = '0;
      req = 4'b0110;
      serve(2, 32'h0BAD_F00D, 1'b1, o);
      n_cmp++; if ({o.gnt, o.ackv} !== {4'b0010, 4'b0010}) begin n_bad++;
         $display("FAIL rstmid_restart: got %b/%b expected 0010/0010", o.gnt, o.ackv); end
      n_cmp++; if (o.rdv !== '0) begin n_bad++; $display("FAIL rstmid_rdata: got %h expected 0", o.rdv); end
      serve(4, 32'h2468_ACE0, 1'b0, o);
      n_cmp++; if ({o.gnt, o.errv, o.rdv} !== {4'b0100, 1'b0, 32'h2468_ACE0}) begin n_bad++;
         $display("FAIL rstmid_second: got %b/%b/%h expected 0100/0/2468ace0", o.gnt, o.errv, o.rdv); end
      mdl_rdata = 32'h2468_ACE0;
      mdl_rr = 3;
   endtask

   task automatic test_random();
      obs_t o;
      int w, lat;
      bit hang, exp_err;
      logic [DW-1:0] rd;
      for (int it = 0; it < 60; it++) begin
         for (int i = 0; i < N; i++)
            if (!req[i] && $urandom_range(0, 1) == 1) begin
               set_cmd(i, SW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
               req[i] = 1'b1;
            end
         if (req == '0) begin
            w = $urandom_range(0, N - 1);
            set_cmd(w, SW'($urandom_range(1, 3)), 1'b0, AW'($urandom), DW'($urandom));
            req[w] = 1'b1;
         end
         w       = pick(req, mdl_rr);
         hang    = (c_sel[w] != '0) && ($urandom_range(0, 7) == 0);
         lat     = $urandom_range(2, 6);
         rd      = DW'($urandom);
         exp_err = (c_sel[w] == '0) || hang;
         serve(lat, rd, hang, o);
         n_cmp++; if ({o.gnt, o.ackv, o.ack_next} !== {N'(1) << w, N'(1) << w, N'(0)}) begin n_bad++;
            $display("FAIL rand_grant[%0d]: got %b/%b/%b expected winner %0d", it, o.gnt, o.ackv, o.ack_next, w); end
         n_cmp++; if (o.errv !== exp_err || o.starts !== ((c_sel[w] != '0) ? 1 : 0)) begin n_bad++;
            $display("FAIL rand_err[%0d]: got err %b starts %0d expected err %b sel %0d", it, o.errv, o.starts, exp_err, c_sel[w]); end
         if (o.starts == 1) begin
            n_cmp++; if ({o.s_sel, o.s_write, o.s_addr, o.s_wdata} !== {c_sel[w], c_write[w], c_addr[w], c_wdata[w]}) begin n_bad++;
               $display("FAIL rand_cmd[%0d]: got %h expected %h", it, {o.s_sel, o.s_write, o.s_addr, o.s_wdata},
                        {c_sel[w], c_write[w], c_addr[w], c_wdata[w]}); end
         end
         if (!exp_err && !c_write[w]) mdl_rdata = rd;
         n_cmp++; if (o.rdv !== mdl_rdata) begin n_bad++;
            $display("FAIL rand_rdata[%0d]: got %h expected %h", it, o.rdv, mdl_rdata); end
         mdl_rr = (w + 1) % N;
      end
   endtask

   initial begin
      reset = 1'b1; req = '0; req_sel = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      m_stable = 1'b1; m_rdata = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_invalid_sel();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
